// File: rtl/sram_responder.sv
// Behavioural 16-bit asynchronous-style SRAM responder with a fixed read latency,
// byte-lane masks and an independent preload port for boot-time memory initialisation.
module sram_responder #(
  parameter int ADDR_W       = 18,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [15:0]       data,
  input  logic              wre,
  input  logic              oute,
  input  logic              hb_mask,
  input  logic              lb_mask,
  input  logic              chip_en,
  output logic              rd_valid,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WRITE} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic              hb_cap_q, hb_cap_d;
  logic              lb_cap_q, lb_cap_d;
  logic              rd_valid_q, rd_valid_d;
  logic [15:0]       rdata_q;
  logic [15:0]       mem [DEPTH];

  logic              is_read, is_write, in_read, changed, bus_we;
  logic [1:0]        lane_mask;
  logic [1:0]        drive_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_addr_d = cap_addr_q;
    hb_cap_d   = hb_cap_q;
    lb_cap_d   = lb_cap_q;
    is_write   = !chip_en && !wre;
    is_read    = !chip_en && wre && !oute;
    in_read    = (state_q == RD_WAIT) || (state_q == RD_DRIVE);
    changed    = (addr != cap_addr_q) || (hb_mask != hb_cap_q) || (lb_mask != lb_cap_q);
    bus_we     = is_write && !reset;

    if (is_write) begin
      state_d = WRITE;
      cnt_d   = 3'd0;
    end else if (is_read) begin
      if (!in_read || changed) begin
        cap_addr_d = addr;
        hb_cap_d   = hb_mask;
        lb_cap_d   = lb_mask;
        cnt_d      = LAT_INIT;
        // A recapture always passes through RD_WAIT so rd_valid visibly drops.
        state_d    = (READ_LATENCY == 1 && !in_read) ? RD_DRIVE : RD_WAIT;
      end else if (state_q == RD_WAIT) begin
        if (cnt_q == 3'd0) state_d = RD_DRIVE;
        else               cnt_d   = cnt_q - 3'd1;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end

    rd_valid_d = (state_d == RD_DRIVE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      cap_addr_q <= '0;
      hb_cap_q   <= 1'b1;
      lb_cap_q   <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_addr_q <= cap_addr_d;
      hb_cap_q   <= hb_cap_d;
      lb_cap_q   <= lb_cap_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign lane_mask = {hb_mask, lb_mask};

  // Preload is written last so it overrides a bus write to the same word;
  // the read port forwards a same-edge preload so it is never missed.
  always_ff @(posedge clock) begin
    if (bus_we) begin
      for (int b = 0; b < 2; b++) begin
        if (!lane_mask[b]) mem[addr][b*8 +: 8] <= data[b*8 +: 8];
      end
    end
    if (ld_en) mem[ld_addr] <= ld_data;
    if (ld_en && (ld_addr == cap_addr_d)) rdata_q <= ld_data;
    else                                  rdata_q <= mem[cap_addr_d];
  end

  assign drive_en = {(state_q == RD_DRIVE) && !hb_cap_q, (state_q == RD_DRIVE) && !lb_cap_q};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign data[gi*8 +: 8] = drive_en[gi] ? rdata_q[gi*8 +: 8] : 8'hzz;
  end

  assign rd_valid = rd_valid_q;

endmodule
